// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared encodings for the shift-register sequence controller:
//   - sel codes driven to every mux_4to1 register cell
//   - cmd_op codes accepted on the command interface
//   - FSM state enum (also exposed on the controller's debug port)
// ---------------------------------------------------------------------------
package usr_pkg;

    // Mode select to each register cell
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // Command opcodes
    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHR      = 2'b01;
    localparam logic [1:0] OP_SHL      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Shift direction used for an opcode once shifting starts.
    // Only SHL shifts left; SHR and LOAD_SHR both shift right.
    function automatic logic [1:0] shift_sel(input logic [1:0] op);
        return (op == OP_SHL) ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/usr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// usr_seq_ctrl
// Sequence controller for a universal shift register built from mux_4to1
// cells. Accepts one command at a time and drives the per-cell mode select
// for the right number of cycles, plus the serial fill bits.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command presented
//   cmd_ready  out  controller can accept a command (IDLE only)
//   cmd_op     in   00 LOAD, 01 SHR, 10 SHL, 11 LOAD_SHR
//   cmd_cnt    in   number of shift cycles (unsigned, CNT_W bits)
//   cmd_rot    in   1: recirculate end bit, 0: shift in cmd_fill
//   cmd_fill   in   serial fill value
//   abort      in   cancel the active command (LOAD/SHIFT only)
//   q_lsb      in   register LSB from datapath
//   q_msb      in   register MSB from datapath
//   sel        out  cell mode: 00 hold, 01 shr, 10 shl, 11 load (registered)
//   ser_in_r   out  bit entering the MSB on shift right (combinational)
//   ser_in_l   out  bit entering the LSB on shift left (combinational)
//   busy       out  command in progress (registered)
//   done       out  one-cycle completion pulse (registered)
//   fsm_state  out  current FSM state, for debug/checkers
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on the FSM state, never on
// cmd_valid, and the command fields are captured on that same edge; the
// source may hold cmd_valid high while the controller is busy.
// ---------------------------------------------------------------------------
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic             abort,
    input  logic             q_lsb,
    input  logic             q_msb,
    output logic [1:0]       sel,
    output logic             ser_in_r,
    output logic             ser_in_l,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rot_q;
    logic             fill_q;
    logic [CNT_W-1:0] ctr;

    assign cmd_ready = (state == ST_IDLE);
    assign fsm_state = state;

    // Serial inputs come from the latched command, so they stay stable for
    // the whole shift even if the command bus changes underneath.
    assign ser_in_r = rot_q ? q_lsb : fill_q;
    assign ser_in_l = rot_q ? q_msb : fill_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            cnt_q  <= '0;
            rot_q  <= 1'b0;
            fill_q <= 1'b0;
            ctr    <= '0;
            sel    <= SEL_HOLD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the entry into DONE sets it
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sel  <= SEL_HOLD;
                    busy <= 1'b0;
                    // abort is deliberately not looked at here
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        cnt_q  <= cmd_cnt;
                        rot_q  <= cmd_rot;
                        fill_q <= cmd_fill;
                        if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR) begin
                            state <= ST_LOAD;
                            sel   <= SEL_LOAD;
                            busy  <= 1'b1;
                        end else if (cmd_cnt != '0) begin
                            state <= ST_SHIFT;
                            sel   <= shift_sel(cmd_op);
                            busy  <= 1'b1;
                            ctr   <= cmd_cnt;
                        end else begin
                            // zero-length shift: nothing to do but report
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        sel   <= SEL_HOLD;
                        busy  <= 1'b0;
                    end else if (op_q == OP_LOAD_SHR && cnt_q != '0) begin
                        state <= ST_SHIFT;
                        sel   <= SEL_SHR;
                        ctr   <= cnt_q;
                    end else begin
                        state <= ST_DONE;
                        sel   <= SEL_HOLD;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    // ctr holds the number of shift cycles still to run,
                    // including the current one; leave when it reads 1.
                    if (abort) begin
                        state <= ST_IDLE;
                        sel   <= SEL_HOLD;
                        busy  <= 1'b0;
                    end else if (ctr == CNT_W'(1)) begin
                        state <= ST_DONE;
                        sel   <= SEL_HOLD;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ctr   <= '0;
                    end else begin
                        ctr <= ctr - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    sel   <= SEL_HOLD;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    sel   <= SEL_HOLD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
